// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Purpose  : Multi-stage input synchroniser with registered-delay edge detect.
//  Revision : 1.0
// ============================================================================
module sync_edge #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [stages-1:0] r_sync;
  logic              r_levelD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_levelD <= 1'b0;
    end else begin
      r_sync   <= {r_sync[stages-2:0], in};
      r_levelD <= r_sync[stages-1];
    end
  end

  assign level = r_sync[stages-1];
  assign rise  = r_sync[stages-1] & ~r_levelD;
  assign fall  = ~r_sync[stages-1] & r_levelD;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures high time and rising-to-rising period of a PWM input.
//  Revision : 1.0
// ============================================================================
module pwm_capture #(
  parameter int nbits       = 16,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [nbits-1:0] high_time,
  output logic [nbits-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [nbits-1:0] c_MAX = '1;
  localparam logic [nbits-1:0] c_ONE = {{(nbits-1){1'b0}}, 1'b1};

  logic             w_s;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  logic [nbits-1:0] r_pcnt;
  logic [nbits-1:0] r_hcnt;
  logic [nbits-1:0] r_highTime;
  logic [nbits-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;
  logic             r_stuckLevel;

  sync_edge #(
    .stages (sync_stages)
  ) u_syncEdge (
    .clk   (clk),
    .rst   (rst),
    .in    (pwm_in),
    .level (w_s),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pcnt       <= '0;
      r_hcnt       <= '0;
      r_highTime   <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_stuckLevel <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_pcnt  <= '0;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_pcnt  <= c_ONE;
              r_hcnt  <= c_ONE;
              r_state <= HIGH;
            end
          end
          HIGH, LOW: begin
            if (w_rise) begin
              r_highTime <= r_hcnt;
              r_period   <= r_pcnt;
              r_valid    <= 1'b1;
              r_timeout  <= 1'b0;
              r_pcnt     <= c_ONE;
              r_hcnt     <= c_ONE;
              r_state    <= HIGH;
            end else if (r_pcnt == c_MAX) begin
              // Line has not toggled for a full counter span: report it stuck.
              r_timeout    <= 1'b1;
              r_stuckLevel <= w_s;
              r_pcnt       <= '0;
              r_hcnt       <= '0;
              r_state      <= IDLE;
            end else begin
              r_pcnt <= r_pcnt + c_ONE;
              if (r_state == HIGH) begin
                if (w_fall) begin
                  r_state <= LOW;
                end else begin
                  r_hcnt <= r_hcnt + c_ONE;
                end
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign high_time   = r_highTime;
  assign period      = r_period;
  assign valid       = r_valid;
  assign timeout     = r_timeout;
  assign stuck_level = r_stuckLevel;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Directed self-checking bench for pwm_capture (nbits=8).
//  Revision : 1.0
// ============================================================================
module tb_pwm_capture;

  localparam int NB   = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;      // pwm_in set at negedge -> valid seen at negedge
  localparam int TMO  = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pwm_in;
  logic [NB-1:0] high_time;
  logic [NB-1:0] period;
  logic          valid;
  logic          timeout;
  logic          stuck_level;

  pwm_capture #(
    .nbits       (NB),
    .sync_stages (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .valid       (valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   cyc;
    int   ht;
    int   per;
    logic to;
  } ev_t;

  ev_t vq[$];
  int  riseQ[$];

  always @(negedge clk) begin
    ev_t e;
    if (valid === 1'b1) begin
      e.cyc = cyc;
      e.ht  = int'(high_time);
      e.per = int'(period);
      e.to  = timeout;
      vq.push_back(e);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic runPwm(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pwm_in = 1'b1;
      riseQ.push_back(cyc);
      repeat (h - 1) @(negedge clk);
      @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h - 1) @(negedge clk);
    end
  endtask

  task automatic applyReset;
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vq.delete();
    riseQ.delete();
  endtask

  task automatic waitTimeout(output int seenCyc);
    int n = 0;
    while (timeout !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    seenCyc = cyc;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    idle(3);
    checks++;
    if ({high_time, period, valid, timeout, stuck_level} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ht=%0d per=%0d v=%b to=%b sl=%b, want all 0",
               high_time, period, valid, timeout, stuck_level);
    end
    rst = 1'b0;
    en  = 1'b1;
    idle(2);
    runPwm(30, 100, 3);
    checks++;
    if (high_time !== 8'd30 || period !== 8'd100) begin
      errors++;
      $display("FAIL pre_reset_meas: got %0d/%0d, want 30/100", high_time, period);
    end
    @(negedge clk);
    pwm_in = 1'b1;
    idle(10);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({high_time, period, valid, timeout, stuck_level} !== '0) begin
      errors++;
      $display("FAIL async_reset: got ht=%0d per=%0d v=%b to=%b sl=%b, want all 0",
               high_time, period, valid, timeout, stuck_level);
    end
    vq.delete();
    idle(3);
    rst    = 1'b0;
    pwm_in = 1'b0;
    idle(20);
    runPwm(10, 20, 1);
    idle(10);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d strobes, want 0", vq.size());
    end
  endtask

  task automatic test_steady;
    applyReset();
    en = 1'b1;
    idle(5);
    runPwm(30, 100, 4);
    idle(5);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL steady_count: got %0d strobes, want 3", vq.size());
    end
    for (int i = 0; i < vq.size() && i + 1 < riseQ.size(); i++) begin
      checks++;
      if (vq[i].ht != 30 || vq[i].per != 100 || vq[i].cyc != riseQ[i+1] + LAT) begin
        errors++;
        $display("FAIL steady_%0d: got %0d/%0d at cyc %0d, want 30/100 at cyc %0d",
                 i, vq[i].ht, vq[i].per, vq[i].cyc, riseQ[i+1] + LAT);
      end
    end
  endtask

  task automatic test_duty_change;
    int expHt[3];
    expHt = '{30, 30, 70};
    applyReset();
    en = 1'b1;
    idle(5);
    runPwm(30, 100, 2);
    runPwm(70, 100, 2);
    idle(5);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL duty_count: got %0d strobes, want 3", vq.size());
    end
    for (int i = 0; i < vq.size() && i < 3 && i + 1 < riseQ.size(); i++) begin
      checks++;
      if (vq[i].ht != expHt[i] || vq[i].per != 100 || vq[i].cyc != riseQ[i+1] + LAT) begin
        errors++;
        $display("FAIL duty_%0d: got %0d/%0d at cyc %0d, want %0d/100 at cyc %0d",
                 i, vq[i].ht, vq[i].per, vq[i].cyc, expHt[i], riseQ[i+1] + LAT);
      end
    end
  endtask

  task automatic test_stuck_high;
    int last;
    int seen;
    applyReset();
    en = 1'b1;
    idle(5);
    runPwm(30, 100, 2);
    @(negedge clk);
    pwm_in = 1'b1;
    last   = cyc;
    waitTimeout(seen);
    checks++;
    if (timeout !== 1'b1 || seen != last + LAT + TMO) begin
      errors++;
      $display("FAIL stuck_high_timeout: got to=%b at cyc %0d, want 1 at cyc %0d",
               timeout, seen, last + LAT + TMO);
    end
    checks++;
    if (stuck_level !== 1'b1 || high_time !== 8'd30 || period !== 8'd100 || vq.size() != 2) begin
      errors++;
      $display("FAIL stuck_high_hold: got sl=%b %0d/%0d n=%0d, want sl=1 30/100 n=2",
               stuck_level, high_time, period, vq.size());
    end
    pwm_in = 1'b0;
    idle(5);
    vq.delete();
    riseQ.delete();
    runPwm(10, 20, 1);
    checks++;
    if (timeout !== 1'b1 || vq.size() != 0) begin
      errors++;
      $display("FAIL resume_arm: got to=%b n=%0d, want to=1 n=0", timeout, vq.size());
    end
    runPwm(10, 20, 2);
    idle(5);
    checks++;
    if (vq.size() != 2) begin
      errors++;
      $display("FAIL resume_count: got %0d strobes, want 2", vq.size());
    end else begin
      checks++;
      if (vq[0].ht != 10 || vq[0].per != 20 || vq[0].to !== 1'b0 || vq[0].cyc != riseQ[1] + LAT) begin
        errors++;
        $display("FAIL resume_first: got %0d/%0d to=%b cyc %0d, want 10/20 to=0 cyc %0d",
                 vq[0].ht, vq[0].per, vq[0].to, vq[0].cyc, riseQ[1] + LAT);
      end
    end
  endtask

  task automatic test_stuck_low_min;
    int seen;
    applyReset();
    en = 1'b1;
    idle(5);
    runPwm(1, 2, 4);
    idle(3);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL min_count: got %0d strobes, want 3", vq.size());
    end
    for (int i = 0; i < vq.size() && i + 1 < riseQ.size(); i++) begin
      checks++;
      if (vq[i].ht != 1 || vq[i].per != 2 || vq[i].cyc != riseQ[i+1] + LAT) begin
        errors++;
        $display("FAIL min_%0d: got %0d/%0d at cyc %0d, want 1/2 at cyc %0d",
                 i, vq[i].ht, vq[i].per, vq[i].cyc, riseQ[i+1] + LAT);
      end
    end
    waitTimeout(seen);
    checks++;
    if (timeout !== 1'b1 || stuck_level !== 1'b0 || seen != riseQ[3] + LAT + TMO) begin
      errors++;
      $display("FAIL stuck_low: got to=%b sl=%b at cyc %0d, want to=1 sl=0 at cyc %0d",
               timeout, stuck_level, seen, riseQ[3] + LAT + TMO);
    end
  endtask

  task automatic test_enable;
    applyReset();
    en = 1'b1;
    idle(5);
    runPwm(20, 100, 2);
    idle(40);
    en = 1'b0;
    vq.delete();
    runPwm(50, 100, 3);
    checks++;
    if (vq.size() != 0 || high_time !== 8'd20 || period !== 8'd100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL en_low_hold: got n=%0d %0d/%0d to=%b, want n=0 20/100 to=0",
               vq.size(), high_time, period, timeout);
    end
    en = 1'b1;
    vq.delete();
    riseQ.delete();
    runPwm(40, 100, 3);
    idle(5);
    checks++;
    if (vq.size() != 2) begin
      errors++;
      $display("FAIL reenable_count: got %0d strobes, want 2", vq.size());
    end else begin
      checks++;
      if (vq[0].ht != 40 || vq[0].per != 100 || vq[0].cyc != riseQ[1] + LAT) begin
        errors++;
        $display("FAIL reenable_first: got %0d/%0d at cyc %0d, want 40/100 at cyc %0d",
                 vq[0].ht, vq[0].per, vq[0].cyc, riseQ[1] + LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_stuck_high();
    test_stuck_low_min();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
